// File: rtl/native_mem_mp.sv
// Multi-port word memory on the native valid/ready bus with round-robin read and write arbitration.
// Define NATIVE_MEM_RANGE_CHECK_EN to flag out-of-range addresses instead of wrapping them mod DEPTH.
module native_mem_mp #(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             raddr_valid,
  output logic [NUM_PORTS-1:0]             raddr_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  raddr,
  output logic [NUM_PORTS-1:0]             rdata_valid,
  input  logic [NUM_PORTS-1:0]             rdata_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata,
  input  logic [NUM_PORTS-1:0]             waddr_valid,
  output logic [NUM_PORTS-1:0]             waddr_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  waddr,
  input  logic [NUM_PORTS-1:0]             wdata_valid,
  output logic [NUM_PORTS-1:0]             wdata_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
  output logic [NUM_PORTS-1:0]             addr_err
);
  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned BOFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] raddr_a [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] waddr_a [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];

  logic [1:0]            state_q [NUM_PORTS];
  logic [1:0]            state_d [NUM_PORTS];
  logic [CNT_W-1:0]      cnt_q   [NUM_PORTS];
  logic [CNT_W-1:0]      cnt_d   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rdata_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rdata_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]  rerr_q, rerr_d, addr_err_q, addr_err_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                  run_q;

  logic [NUM_PORTS-1:0]  rd_idle, rd_elig, wr_elig, rd_gnt, wr_gnt;
  logic [PTR_W-1:0]      rd_cand, wr_cand, rd_win, wr_win;
  logic                  rd_any, wr_any, rd_oor, wr_oor, wr_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_addr_bits;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[BOFF_W +: IDX_W];
  endfunction

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign raddr_a[p] = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign waddr_a[p] = waddr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[p] = wdata[p*DATA_WIDTH +: DATA_WIDTH];
    assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
    assign rdata_valid[p] = (state_q[p] == ST_DATA);
    assign rd_idle[p]     = (state_q[p] == ST_IDLE);
  end

  // Byte-offset bits are ignored; upper bits only matter when range checking.
  assign unused_addr_bits = ^{raddr, waddr};

  // Grants are held off until the first edge after reset release.
  assign rd_elig = raddr_valid & rd_idle & {NUM_PORTS{run_q}};
  assign wr_elig = waddr_valid & wdata_valid & {NUM_PORTS{run_q}};

  // Round-robin search: lowest offset from the pointer wins.
  always_comb begin
    rd_cand = '0;
    wr_cand = '0;
    rd_win  = rd_ptr_q;
    wr_win  = wr_ptr_q;
    rd_any  = 1'b0;
    wr_any  = 1'b0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      rd_cand = PTR_W'((int'(rd_ptr_q) + i) % int'(NUM_PORTS));
      wr_cand = PTR_W'((int'(wr_ptr_q) + i) % int'(NUM_PORTS));
      if (rd_elig[rd_cand]) begin
        rd_win = rd_cand;
        rd_any = 1'b1;
      end
      if (wr_elig[wr_cand]) begin
        wr_win = wr_cand;
        wr_any = 1'b1;
      end
    end
  end

  assign rd_gnt      = rd_any ? (NUM_PORTS'(1) << rd_win) : '0;
  assign wr_gnt      = wr_any ? (NUM_PORTS'(1) << wr_win) : '0;
  assign raddr_ready = rd_gnt;
  assign waddr_ready = wr_gnt;
  assign wdata_ready = wr_gnt;
  assign rd_ptr_d    = rd_any ? PTR_W'((int'(rd_win) + 1) % int'(NUM_PORTS)) : rd_ptr_q;
  assign wr_ptr_d    = wr_any ? PTR_W'((int'(wr_win) + 1) % int'(NUM_PORTS)) : wr_ptr_q;

`ifdef NATIVE_MEM_RANGE_CHECK_EN
  assign rd_oor = (raddr_a[rd_win] >> (BOFF_W + IDX_W)) != '0;
  assign wr_oor = (waddr_a[wr_win] >> (BOFF_W + IDX_W)) != '0;
`else
  assign rd_oor = 1'b0;
  assign wr_oor = 1'b0;
`endif

  // Read data is captured at the address handshake, so later writes cannot disturb it.
  assign rd_word = rd_oor ? {BYTES{8'hDE}} : mem_q[word_idx(raddr_a[rd_win])];
  assign wr_en   = wr_any && !wr_oor;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[word_idx(waddr_a[wr_win])] <= wdata_a[wr_win];
    end
  end

  // Per-port read channel: IDLE -> WAIT -> DATA -> IDLE.
  always_comb begin
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      state_d[p]    = state_q[p];
      cnt_d[p]      = cnt_q[p];
      rdata_d[p]    = rdata_q[p];
      rerr_d[p]     = rerr_q[p];
      addr_err_d[p] = wr_gnt[p] && wr_oor;
      case (state_q[p])
        ST_IDLE: begin
          if (rd_gnt[p]) begin
            rdata_d[p] = rd_word;
            rerr_d[p]  = rd_oor;
            if (READ_LATENCY == 1) begin
              state_d[p]    = ST_DATA;
              addr_err_d[p] = addr_err_d[p] | rd_oor;
            end else begin
              state_d[p] = ST_WAIT;
              cnt_d[p]   = CNT_W'(READ_LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q[p] <= CNT_W'(1)) begin
            state_d[p]    = ST_DATA;
            addr_err_d[p] = addr_err_d[p] | rerr_q[p];
          end else begin
            cnt_d[p] = CNT_W'(cnt_q[p] - CNT_W'(1));
          end
        end
        ST_DATA: begin
          if (rdata_ready[p]) begin
            state_d[p] = ST_IDLE;
          end
        end
        default: state_d[p] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rerr_q     <= '0;
      addr_err_q <= '0;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        state_q[p] <= ST_IDLE;
        cnt_q[p]   <= '0;
        rdata_q[p] <= '0;
      end
    end else begin
      run_q      <= 1'b1;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rerr_q     <= rerr_d;
      addr_err_q <= addr_err_d;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
        rdata_q[p] <= rdata_d[p];
      end
    end
  end

  assign addr_err = addr_err_q;

endmodule
